megaphone_sprite_fetch: RTL and testbench

//  Upstream stage of the megaphone colour palette. Consumes the VGA raster position and the

---
 rtl/megaphone_sprite_fetch_pkg.sv | 24 ++
 rtl/megaphone_sprite_fetch_if.sv | 40 ++++
 rtl/megaphone_fire_fsm.sv | 85 ++++++++
 rtl/megaphone_sprite_fetch.sv | 100 ++++++++++
 tb/tb_megaphone_sprite_fetch.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/megaphone_sprite_fetch_pkg.sv
//------------------------------------------------------------------------------
// Module : megaphone_pkg
// Brief  : Shared types and constants for the megaphone sprite/palette path.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package megaphone_pkg;

    typedef enum logic [1:0] {
        MP_IDLE     = 2'd0,
        MP_FIRING   = 2'd1,
        MP_COOLDOWN = 2'd2
    } mp_state_t;

    localparam int          PAL_W           = 3;
    localparam logic [2:0]  PAL_TRANSPARENT = 3'd0;
    localparam int          COORD_W         = 10;
    localparam int          SCREEN_W        = 640;
    localparam int          SCREEN_H        = 480;

endpackage

`default_nettype wire

// File: rtl/megaphone_sprite_fetch_if.sv
//------------------------------------------------------------------------------
// Module : megaphone_sprite_fetch_if
// Brief  : Raster, sprite-control and ROM signals of the sprite fetch stage.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface megaphone_sprite_fetch_if
    import megaphone_pkg::*;
#(
    parameter int ADDR_W = 11
);
    logic                frame_start;
    logic [COORD_W-1:0]  pos_x;
    logic [COORD_W-1:0]  pos_y;
    logic                facing_left;
    logic                fire_req;
    logic [COORD_W-1:0]  DrawX;
    logic [COORD_W-1:0]  DrawY;
    logic                pix_valid;
    logic [ADDR_W-1:0]   rom_addr;
    logic [PAL_W-1:0]    rom_data;
    logic [PAL_W-1:0]    select_output;
    logic                sprite_on;
    logic                fire_active;

    modport master (
        output frame_start, pos_x, pos_y, facing_left, fire_req,
        output DrawX, DrawY, pix_valid, rom_data,
        input  rom_addr, select_output, sprite_on, fire_active
    );

    modport slave (
        input  frame_start, pos_x, pos_y, facing_left, fire_req,
        input  DrawX, DrawY, pix_valid, rom_data,
        output rom_addr, select_output, sprite_on, fire_active
    );
endinterface

`default_nettype wire

// File: rtl/megaphone_fire_fsm.sv
//------------------------------------------------------------------------------
// Module : megaphone_fire_fsm
// Brief  : Frame-stepped fire animation FSM: pending request, blast, cooldown.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module megaphone_fire_fsm
    import megaphone_pkg::*;
#(
    parameter int FIRE_FRAMES     = 8,
    parameter int COOLDOWN_FRAMES = 16
) (
    input  wire logic Clk,
    input  wire logic Reset_n,
    input  wire logic i_frame_start,
    input  wire logic i_fire_req,
    output logic      o_fire_active,
    output logic      o_anim
);
    localparam int c_MAX_FRAMES = (FIRE_FRAMES > COOLDOWN_FRAMES) ? FIRE_FRAMES : COOLDOWN_FRAMES;
    localparam int c_CNT_W      = (c_MAX_FRAMES > 1) ? $clog2(c_MAX_FRAMES) : 1;

    mp_state_t           r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_pending;
    logic                r_fire_active;
    logic                r_anim;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state       <= MP_IDLE;
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            r_fire_active <= 1'b0;
            r_anim        <= 1'b0;
        end else begin
            case (r_state)
                MP_IDLE: begin
                    // A request arriving on the frame_start cycle itself fires immediately.
                    if (i_frame_start && (r_pending || i_fire_req)) begin
                        r_state       <= MP_FIRING;
                        r_cnt         <= c_CNT_W'(FIRE_FRAMES - 1);
                        r_pending     <= 1'b0;
                        r_fire_active <= 1'b1;
                        r_anim        <= 1'b1;
                    end else if (i_fire_req) begin
                        r_pending <= 1'b1;
                    end
                end
                MP_FIRING: begin
                    if (i_frame_start) begin
                        if (r_cnt == '0) begin
                            r_state       <= MP_COOLDOWN;
                            r_cnt         <= c_CNT_W'(COOLDOWN_FRAMES - 1);
                            r_fire_active <= 1'b0;
                            r_anim        <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                MP_COOLDOWN: begin
                    if (i_frame_start) begin
                        if (r_cnt == '0) begin
                            r_state <= MP_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state       <= MP_IDLE;
                    r_fire_active <= 1'b0;
                    r_anim        <= 1'b0;
                end
            endcase
        end
    end

    assign o_fire_active = r_fire_active;
    assign o_anim        = r_anim;
endmodule

`default_nettype wire

// File: rtl/megaphone_sprite_fetch.sv
//------------------------------------------------------------------------------
// Module : megaphone_sprite_fetch
// Brief  : Sprite hit test, ROM addressing with flip, 3-cycle palette pipeline.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module megaphone_sprite_fetch
    import megaphone_pkg::*;
#(
    parameter int SPR_W           = 32,
    parameter int SPR_H           = 32,
    parameter int FIRE_FRAMES     = 8,
    parameter int COOLDOWN_FRAMES = 16,
    parameter int ADDR_W          = 11
) (
    input  wire logic                 Clk,
    input  wire logic                 Reset_n,
    megaphone_sprite_fetch_if.slave   bus
);
    localparam int c_XW = $clog2(SPR_W);
    localparam int c_YW = $clog2(SPR_H);

    logic [COORD_W-1:0] r_sh_x;
    logic [COORD_W-1:0] r_sh_y;
    logic               r_sh_face;
    logic               w_anim;
    logic               w_fire_active;

    logic [COORD_W:0]   w_dx;
    logic [COORD_W:0]   w_dy;
    logic               w_hit;
    logic [c_XW-1:0]    w_col;
    logic [ADDR_W-1:0]  w_addr;

    logic [ADDR_W-1:0]  r_rom_addr;
    logic               r_s1;
    logic               r_s2;
    logic [PAL_W-1:0]   r_sel;
    logic               r_sprite_on;

    megaphone_fire_fsm #(
        .FIRE_FRAMES     (FIRE_FRAMES),
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
    ) u_fire_fsm (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .i_frame_start (bus.frame_start),
        .i_fire_req    (bus.fire_req),
        .o_fire_active (w_fire_active),
        .o_anim        (w_anim)
    );

    // Position/facing only change at frame boundaries so the sprite never tears.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_sh_x    <= '0;
            r_sh_y    <= '0;
            r_sh_face <= 1'b0;
        end else if (bus.frame_start) begin
            r_sh_x    <= bus.pos_x;
            r_sh_y    <= bus.pos_y;
            r_sh_face <= bus.facing_left;
        end
    end

    // Left of / above the sprite wraps to a large unsigned value and fails the compare.
    always_comb begin
        w_dx   = {1'b0, bus.DrawX} - {1'b0, r_sh_x};
        w_dy   = {1'b0, bus.DrawY} - {1'b0, r_sh_y};
        w_hit  = bus.pix_valid && (w_dx < (COORD_W+1)'(SPR_W)) && (w_dy < (COORD_W+1)'(SPR_H));
        w_col  = r_sh_face ? (c_XW'(SPR_W - 1) - w_dx[c_XW-1:0]) : w_dx[c_XW-1:0];
        w_addr = ADDR_W'({w_anim, w_dy[c_YW-1:0], w_col});
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_rom_addr  <= '0;
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_sel       <= PAL_TRANSPARENT;
            r_sprite_on <= 1'b0;
        end else begin
            if (w_hit) begin
                r_rom_addr <= w_addr;
            end
            r_s1        <= w_hit;
            r_s2        <= r_s1;
            r_sel       <= r_s2 ? bus.rom_data : PAL_TRANSPARENT;
            r_sprite_on <= r_s2 && (bus.rom_data != PAL_TRANSPARENT);
        end
    end

    assign bus.rom_addr      = r_rom_addr;
    assign bus.select_output = r_sel;
    assign bus.sprite_on     = r_sprite_on;
    assign bus.fire_active   = w_fire_active;
endmodule

`default_nettype wire

// File: tb/tb_megaphone_sprite_fetch.sv
//------------------------------------------------------------------------------
// Module : tb_megaphone_sprite_fetch
// Brief  : Directed bench for megaphone_sprite_fetch with a synchronous ROM model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_megaphone_sprite_fetch;

    typedef struct {
        logic [9:0]  px;
        logic [9:0]  py;
        logic        face;
        logic [9:0]  dx;
        logic [9:0]  dy;
        logic        pv;
        logic        hit;
        logic [10:0] addr;
        logic [2:0]  sel;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    megaphone_sprite_fetch_if #(.ADDR_W(11)) bus ();

    megaphone_sprite_fetch #(
        .SPR_W(32), .SPR_H(32), .FIRE_FRAMES(8), .COOLDOWN_FRAMES(16), .ADDR_W(11)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    logic [2:0] mem [2048];
    always @(posedge Clk) bus.rom_data <= mem[bus.rom_addr];

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame(input logic req);
        bus.frame_start = 1'b1;
        bus.fire_req    = req;
        bus.pix_valid   = 1'b0;
        step();
        bus.frame_start = 1'b0;
        bus.fire_req    = 1'b0;
        step();
        step();
    endtask

    task automatic pulse_fire();
        bus.fire_req = 1'b1;
        step();
        bus.fire_req = 1'b0;
        step();
    endtask

    task automatic probe(input string nm, input logic [9:0] x, input logic [9:0] y, input logic pv,
                         input logic hit, input logic [10:0] addr, input logic [2:0] sel);
        bus.DrawX     = x;
        bus.DrawY     = y;
        bus.pix_valid = pv;
        step();
        bus.pix_valid = 1'b0;
        if (hit) chk({nm, " rom_addr"}, 32'(bus.rom_addr), 32'(addr));
        step();
        step();
        chk({nm, " select_output"}, 32'(bus.select_output), 32'(sel));
        chk({nm, " sprite_on"}, 32'(bus.sprite_on), 32'(sel != 3'd0));
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 3'(i % 7 + 1);
        mem[69]  = 3'd4;
        mem[200] = 3'd0;

        //            px   py  face  dx   dy  pv hit  addr   sel
        vecs[0]  = '{100,  50, 1'b0, 105,  52, 1, 1,   69, 3'd4};
        vecs[1]  = '{100,  50, 1'b0, 132,  52, 1, 0,    0, 3'd0};
        vecs[2]  = '{100,  50, 1'b0, 100,  50, 1, 1,    0, 3'd1};
        vecs[3]  = '{100,  50, 1'b0, 131,  81, 1, 1, 1023, 3'd2};
        vecs[4]  = '{100,  50, 1'b0,  99,  50, 1, 0,    0, 3'd0};
        vecs[5]  = '{100,  50, 1'b0, 105,  82, 1, 0,    0, 3'd0};
        vecs[6]  = '{620, 470, 1'b1, 620, 470, 1, 1,   31, 3'd4};
        vecs[7]  = '{620, 470, 1'b1, 639, 470, 1, 1,   12, 3'd6};
        vecs[8]  = '{620, 470, 1'b1,   0, 470, 1, 0,    0, 3'd0};
        vecs[9]  = '{620, 470, 1'b1, 639, 479, 1, 1,  300, 3'd7};
        vecs[10] = '{100,  50, 1'b0, 108,  56, 1, 1,  200, 3'd0};
        vecs[11] = '{100,  50, 1'b0, 105,  52, 0, 0,    0, 3'd0};

        bus.frame_start = 1'b0;
        bus.fire_req    = 1'b0;
        bus.facing_left = 1'b0;
        bus.pos_x       = 10'd0;
        bus.pos_y       = 10'd0;
        bus.DrawX       = 10'd3;
        bus.DrawY       = 10'd2;
        bus.pix_valid   = 1'b1;
        Reset_n         = 1'b0;

        // Reset held mid-frame with active video
        for (int i = 0; i < 4; i++) step();
        chk("reset rom_addr", 32'(bus.rom_addr), 0);
        chk("reset select_output", 32'(bus.select_output), 0);
        chk("reset sprite_on", 32'(bus.sprite_on), 0);
        chk("reset fire_active", 32'(bus.fire_active), 0);

        // First pixel after release at shadow position (0,0): addr 2*32+3=67, mem=5
        Reset_n = 1'b1;
        step();
        bus.pix_valid = 1'b0;
        chk("post-reset rom_addr", 32'(bus.rom_addr), 67);
        chk("post-reset sel N+1", 32'(bus.select_output), 0);
        step();
        chk("post-reset sel N+2", 32'(bus.select_output), 0);
        step();
        chk("post-reset sel N+3", 32'(bus.select_output), 5);
        chk("post-reset sprite_on N+3", 32'(bus.sprite_on), 1);

        for (int i = 0; i < 12; i++) begin
            bus.pos_x       = vecs[i].px;
            bus.pos_y       = vecs[i].py;
            bus.facing_left = vecs[i].face;
            frame(1'b0);
            probe($sformatf("vec%0d", i), vecs[i].dx, vecs[i].dy, vecs[i].pv,
                  vecs[i].hit, vecs[i].addr, vecs[i].sel);
        end

        // Tear-free: position change mid-frame waits for the next frame_start
        bus.pos_x = 10'd100; bus.pos_y = 10'd50; bus.facing_left = 1'b0;
        frame(1'b0);
        bus.pos_x = 10'd200;
        probe("tear old pos", 105, 52, 1, 1, 69, 3'd4);
        probe("tear new pos early", 205, 52, 1, 0, 0, 3'd0);
        frame(1'b0);
        probe("tear new pos", 205, 52, 1, 1, 69, 3'd4);

        // Fire sequence
        bus.pos_x = 10'd100;
        frame(1'b0);
        pulse_fire();
        chk("fire pending no blast yet", 32'(bus.fire_active), 0);
        frame(1'b0);
        chk("fire frame0 active", 32'(bus.fire_active), 1);
        probe("fire anim addr", 105, 52, 1, 1, 1093, 3'd2);
        for (int f = 1; f < 8; f++) begin
            frame(1'b0);
            chk($sformatf("fire frame%0d active", f), 32'(bus.fire_active), 1);
        end
        frame(1'b0);
        chk("cooldown entry inactive", 32'(bus.fire_active), 0);
        probe("cooldown anim off", 105, 52, 1, 1, 69, 3'd4);
        for (int f = 9; f < 24; f++) begin
            frame(f == 12);
            chk($sformatf("cooldown frame%0d inactive", f), 32'(bus.fire_active), 0);
        end
        pulse_fire();
        frame(1'b0);
        chk("cooldown end idle", 32'(bus.fire_active), 0);
        frame(1'b0);
        chk("cooldown req dropped", 32'(bus.fire_active), 0);
        pulse_fire();
        frame(1'b0);
        chk("refire active", 32'(bus.fire_active), 1);

        // Reset mid-shot aborts and clears pending
        Reset_n = 1'b0;
        step();
        step();
        chk("midshot reset fire_active", 32'(bus.fire_active), 0);
        Reset_n = 1'b1;
        frame(1'b0);
        chk("after reset no refire", 32'(bus.fire_active), 0);
        frame(1'b1);
        chk("same-cycle req+frame fires", 32'(bus.fire_active), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
